m_axi_burst_wr: RTL
===================

Name: m_axi_burst_wr

Overview:
- Parametrised AXI4 write master, successor to the single-burst writer.
- Accepts a write command (start address, total beat count) over a valid/ready handshake, plus a valid/ready data stream.
- Splits the transfer into INCR bursts that never exceed MAX_BURST_LEN beats and never cross a 4 KB boundary.
- Sits between DMA/frame-writer logic and the AXI interconnect/DDR controller; reports completion and an accumulated response error.

Parameters:
- C_M_AXI_ID_WIDTH, 1, width of awid/bid; awid driven to AXI_ID.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, data width; one of 32/64/128/256.
- MAX_BURST_LEN, 16, maximum beats per burst; 1..256.
- LEN_WIDTH, 16, width of the total beat count.
- AXI_ID, 0, constant awid value.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept; high only in IDLE
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  start byte address
- cmd_beats  in  LEN_WIDTH  total beats to write
- wr_data  in  C_M_AXI_DATA_WIDTH  write data stream
- wr_valid  in  1  data valid
- wr_ready  out  1  data accepted when wr_valid && wr_ready
- wr_done  out  1  one-cycle pulse at command completion
- wr_err  out  1  valid with wr_done; 1 if any bresp[1] was set
- axi_awid/awaddr/awlen/awsize/awburst/awcache/awprot/awvalid  out  per AXI4  write address channel
- axi_awready  in  1
- axi_wdata/wstrb/wlast/wvalid  out  per AXI4  write data channel
- axi_wready  in  1
- axi_bid  in  C_M_AXI_ID_WIDTH
- axi_bresp  in  2
- axi_bvalid  in  1
- axi_bready  out  1

Behaviour:
- Constant outputs:
  - awsize = log2(DATA_W/8)
  - awburst = 2'b01
  - awcache = 4'b0010
  - awprot = 0
  - wstrb = all ones
- Reset (async, rst_n low): state IDLE; awvalid, wvalid, bready, wr_done, wr_err = 0; awaddr, awlen = 0; internal counters = 0. Reset mid-burst abandons the transfer immediately; no completion pulse.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_addr with the low log2(DATA_W/8) bits forced to 0, latch remaining=cmd_beats, clear error accumulator.
  - If cmd_beats==0: pulse wr_done the next cycle with wr_err=0 and stay in IDLE.
  - Otherwise go to AW.
- AW:
  - burst = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) / bytes_per_beat).
  - awaddr = current address, awlen = burst-1, awvalid=1.
  - awaddr/awlen are registered and held stable while awvalid is high.
  - On awvalid && awready: awvalid drops next cycle; go to W.
- W:
  - Pass-through: axi_wvalid=wr_valid, wr_ready=axi_wready, axi_wdata=wr_data.
  - Beat counter increments on each handshake.
  - axi_wlast=1 when beat counter == awlen.
  - On handshake with wlast: go to B; remaining -= burst; address += burst*bytes_per_beat.
  - wvalid/wr_ready forced 0 outside W.
- B:
  - bready=1.
  - On bvalid && bready: OR bresp[1] into the error accumulator.
  - If remaining>0: go to AW. Otherwise assert wr_done for 1 cycle with wr_err = accumulator, and go to IDLE.
- Only one burst is outstanding at a time; the AW of burst n+1 is not issued before the B of burst n.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH without error.
- bid is ignored.
- A bvalid seen outside B is held off (bready=0).
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Throughput: 1 beat/cycle in W when wr_valid and wready are both held high.

Optional Feature:
- Macro: M_AXI_BURST_WR_PERF_CNT_EN.
- When defined:
  - Extra output perf_beats[31:0] counts every W handshake since reset.
  - Extra output perf_stall[31:0] counts cycles in W with wvalid=1 and wready=0.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- DATA_W=32, MAX=16, cmd_addr=0x1000, beats=16, ready always 1 -> one AW (0x1000, awlen=15), 16 beats, wlast on beat 16, wr_done=1, wr_err=0.
- cmd_addr=0x0FF0, beats=8 -> AW 0x0FF0 awlen=3, then AW 0x1000 awlen=3; no burst crosses 4 KB; a single wr_done.
- cmd_addr=0x2000, beats=40 -> bursts of awlen 15, 15, 7 at 0x2000, 0x2040, 0x2080; next AW only after the previous B handshake.
- beats=20 with bresp=2'b10 on the first B only -> both bursts complete; wr_done with wr_err=1; the next command reports wr_err=0 when its responses are OKAY.
- Random wready/wr_valid stalls, and awready held low 5 cycles -> awvalid/awaddr stable during the stall; data order preserved; beat count exact; cmd_beats=0 -> wr_done next cycle, no AXI activity.
- rst_n asserted in the middle of W -> all AXI valids and bready 0 immediately; after release a new command at 0x3000 with 4 beats completes normally.

Source files
------------

// File: rtl/m_axi_burst_wr.sv
// AXI4 write master: splits a command into INCR bursts capped at MAX_BURST_LEN that never cross 4 KB.
// Optional M_AXI_BURST_WR_PERF_CNT_EN adds saturating beat/stall performance counters.
module m_axi_burst_wr #(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int MAX_BURST_LEN      = 16,
    parameter int LEN_WIDTH          = 16,
    parameter int AXI_ID             = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]            cmd_beats,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    output logic                            wr_done,
    output logic                            wr_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]     axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]                      axi_awlen,
    output logic [2:0]                      axi_awsize,
    output logic [1:0]                      axi_awburst,
    output logic [3:0]                      axi_awcache,
    output logic [2:0]                      axi_awprot,
    output logic                            axi_awvalid,
    input  logic                            axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                            axi_wlast,
    output logic                            axi_wvalid,
    input  logic                            axi_wready,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     axi_bid,
    input  logic [1:0]                      axi_bresp,
    input  logic                            axi_bvalid,
    output logic                            axi_bready
`ifdef M_AXI_BURST_WR_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_beats,
    output logic [31:0]                     perf_stall
`endif
);
    localparam int AW  = C_M_AXI_ADDR_WIDTH;
    localparam int BPB = C_M_AXI_DATA_WIDTH / 8;
    localparam int SZ  = $clog2(BPB);
    localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(BPB - 1));

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    state_t               state;
    logic [AW-1:0]        addr_q;
    logic [LEN_WIDTH-1:0] remaining;
    logic [8:0]           beat_cnt;
    logic                 err_acc;
    logic [AW-1:0]        cmd_addr_al;
    logic [8:0]           cur_burst;
    logic                 w_hs;
    logic                 unused_ok;

    // Beats in the next burst: limited by what is left, the burst cap and the distance to the 4 KB page end.
    function automatic logic [8:0] calc_burst(input logic [AW-1:0] a, input logic [LEN_WIDTH-1:0] rem);
        logic [31:0] to4k;
        logic [31:0] b;
        to4k = (32'd4096 - {20'd0, a[11:0]}) >> SZ;
        b    = 32'(rem);
        if (b > 32'(MAX_BURST_LEN)) b = 32'(MAX_BURST_LEN);
        if (b > to4k) b = to4k;
        return b[8:0];
    endfunction

    function automatic logic [7:0] calc_awlen(input logic [AW-1:0] a, input logic [LEN_WIDTH-1:0] rem);
        logic [8:0] l;
        l = calc_burst(a, rem) - 9'd1;
        return l[7:0];
    endfunction

    assign cmd_addr_al = cmd_addr & ALIGN_MASK;
    assign cur_burst   = {1'b0, axi_awlen} + 9'd1;

    assign axi_awid    = C_M_AXI_ID_WIDTH'(AXI_ID);
    assign axi_awsize  = 3'(SZ);
    assign axi_awburst = 2'b01;
    assign axi_awcache = 4'b0010;
    assign axi_awprot  = 3'b000;
    assign axi_wstrb   = '1;

    assign cmd_ready  = (state == S_IDLE);
    assign axi_wvalid = (state == S_W) && wr_valid;
    assign wr_ready   = (state == S_W) && axi_wready;
    assign axi_wdata  = wr_data;
    assign axi_wlast  = (state == S_W) && (beat_cnt == {1'b0, axi_awlen});
    assign axi_bready = (state == S_B);
    assign w_hs       = axi_wvalid && axi_wready;

    assign unused_ok = ^{axi_bid, axi_bresp[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            remaining   <= '0;
            beat_cnt    <= '0;
            err_acc     <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awvalid <= 1'b0;
            wr_done     <= 1'b0;
            wr_err      <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr_al;
                        remaining <= cmd_beats;
                        err_acc   <= 1'b0;
                        beat_cnt  <= '0;
                        if (cmd_beats == '0) begin
                            wr_done <= 1'b1;
                        end else begin
                            state       <= S_AW;
                            axi_awvalid <= 1'b1;
                            axi_awaddr  <= cmd_addr_al;
                            axi_awlen   <= calc_awlen(cmd_addr_al, cmd_beats);
                        end
                    end
                end
                S_AW: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        state       <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        if (axi_wlast) begin
                            beat_cnt  <= '0;
                            remaining <= remaining - LEN_WIDTH'(cur_burst);
                            addr_q    <= addr_q + (AW'(cur_burst) << SZ);
                            state     <= S_B;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                        end
                    end
                end
                S_B: begin
                    if (axi_bvalid) begin
                        err_acc <= err_acc | axi_bresp[1];
                        if (remaining != '0) begin
                            state       <= S_AW;
                            axi_awvalid <= 1'b1;
                            axi_awaddr  <= addr_q;
                            axi_awlen   <= calc_awlen(addr_q, remaining);
                        end else begin
                            wr_done <= 1'b1;
                            wr_err  <= err_acc | axi_bresp[1];
                            state   <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef M_AXI_BURST_WR_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (w_hs && (perf_beats != '1))
                perf_beats <= perf_beats + 32'd1;
            if (axi_wvalid && !axi_wready && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
